// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
// The fetch queue entry carries the PC, the raw instruction word and the JAL-predecode flag.
package fetch_pkg;

  localparam int XLEN_W     = 32;
  localparam int INSN_BYTES = 4;

  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef struct packed {
    logic [XLEN_W-1:0] pc;
    logic [XLEN_W-1:0] insn;
    logic              jal_pred;
  } fetch_entry_t;

  // Takes insn[31:12] and rebuilds the sign-extended, byte-granular J-type offset.
  function automatic logic [XLEN_W-1:0] j_imm(input logic [19:0] hi);
    return {{12{hi[19]}}, hi[7:0], hi[8], hi[18:9], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry prefetch queue of fetch_entry_t with push, pop and synchronous flush.
// Flush wins over a same-cycle push; a pop on an empty queue is ignored.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != '0);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The credit rule upstream must make a push into a full, non-draining queue impossible.
  always @(posedge clock) begin
    if (reset) begin
      assert (!(push && !flush && !do_pop && (count_q == CW'(DEPTH))));
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generator, variable-latency imem interface and prefetch queue.
// Optional JAL predecode (fetch follows JALs itself) is enabled by defining FETCH_JAL_PREDECODE_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h01000000,
  parameter int          XLEN      = 32,
  parameter int          DEPTH     = 4
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            insn_valid,
  output logic [XLEN-1:0] insn,
  output logic [XLEN-1:0] insn_pc,
  output logic            insn_jal_pred,
  input  logic            dec_ready
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   count;
  logic [CW:0]     in_use;
  logic            credit_ok;
  logic            req_fire;
  logic            resp_keep;
  logic            jal_hit;
  logic            fifo_push;
  logic            fifo_pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // Queued plus in-flight entries may never exceed DEPTH, so every response has a slot.
  assign in_use    = {1'b0, count} + {1'b0, outstanding_q};
  assign credit_ok = in_use < (CW+1)'(DEPTH);
  assign resp_keep = imem_resp_valid && (drop_cnt_q == '0);

`ifdef FETCH_JAL_PREDECODE_EN
  assign jal_hit = resp_keep && (imem_resp_data[6:0] == OP_JAL);
`else
  assign jal_hit = 1'b0;
`endif

  assign imem_req_valid = reset && credit_ok && !redirect_valid && !jal_hit;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign insn_valid = (count != '0);
  assign fifo_pop   = insn_valid && dec_ready && !redirect_valid;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);
    fifo_push     = 1'b0;
    push_entry    = '{pc: resp_pc_q, insn: imem_resp_data, jal_pred: jal_hit};
    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + XLEN'(INSN_BYTES);
    end
    if (imem_resp_valid) begin
      if (drop_cnt_q != '0) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end else begin
        fifo_push = 1'b1;
        resp_pc_d = resp_pc_q + XLEN'(INSN_BYTES);
      end
    end
    // A followed JAL keeps the queue but squashes everything fetched past it.
    if (jal_hit) begin
      fetch_pc_d = resp_pc_q + j_imm(imem_resp_data[31:12]);
      resp_pc_d  = fetch_pc_d;
      drop_cnt_d = outstanding_q - CW'(1);
    end
    if (redirect_valid) begin
      fifo_push  = 1'b0;
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      drop_cnt_d = outstanding_q - CW'(imem_resp_valid);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= XLEN'(BASE_ADDR);
      resp_pc_q     <= XLEN'(BASE_ADDR);
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  always @(posedge clock) begin
    if (reset) begin
      assert (!(imem_resp_valid && (outstanding_q == '0)));
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .flush      (redirect_valid),
    .head       (head),
    .count      (count)
  );

  assign insn          = insn_valid ? head.insn : '0;
  assign insn_pc       = insn_valid ? head.pc : '0;
  assign insn_jal_pred = insn_valid && head.jal_pred;

endmodule
